// File: rtl/data_ram_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder and its byte-enabled RAM.
package data_ram_responder_pkg;

    localparam int CNT_W = 4;

    typedef logic [1:0] state_t;
    typedef logic [3:0] laneMask_t;

    localparam state_t IDLE    = 2'b00;
    localparam state_t WAITING = 2'b01;
    localparam state_t RESP    = 2'b10;

    localparam laneMask_t WEN_NONE = 4'b0000;
    localparam laneMask_t WEN_WORD = 4'b1111;

    // Word seen after a lane-masked write: selected bytes from newWord, the rest from oldWord.
    function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input laneMask_t   wen);
        logic [31:0] merged;
        merged = oldWord;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_ram_responder_bram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// write-through output (merged post-write word on writes, stored word on reads).
module bram_be
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] wordAddr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [2**ADDR_W];
    logic [31:0] merged_s;
    logic [31:0] rdata_r;

    // Post-write view of the addressed word.
    always_comb begin
        merged_s = mergeLanes(mem_r[wordAddr], wdata, wen);
    end

    // Byte-lane array update; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req && wen[i]) begin
                mem_r[wordAddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Output register: loads only on a commit, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (req) begin
            rdata_r <= merged_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder for the pipeline data port: accepts one word request,
// inserts WAIT wait states, commits to the local RAM and pulses rvalid.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy
);

    localparam bit               ZERO_WAIT   = (WAIT == 0);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_RELOAD  = ZERO_WAIT ? CNT_ZERO : CNT_W'(WAIT - 1);

    state_t             state_r;
    state_t             stateNext_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cntNext_s;
    logic               accept_s;
    logic               commit_s;
    logic               rvalid_r;

    logic [3:0]         reqWen_r;
    logic [ADDR_W-1:0]  reqAddr_r;
    logic [31:0]        reqWdata_r;

    logic [3:0]         ramWen_s;
    logic [ADDR_W-1:0]  ramAddr_s;
    logic [31:0]        ramWdata_s;
    logic               unusedAddrBits_s;

    assign unusedAddrBits_s = ^{addr[31:ADDR_W+2], addr[1:0]};

    // Acceptance and the edge on which the RAM access happens; reset vetoes a commit.
    always_comb begin
        accept_s = en && (state_r != WAITING);
        commit_s = !rst && ((ZERO_WAIT && accept_s) ||
                            ((state_r == WAITING) && (cnt_r == CNT_ZERO)));
    end

    // Next-state and wait-counter logic.
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = cnt_r;
        case (state_r)
            IDLE, RESP: begin
                if (accept_s) begin
                    if (ZERO_WAIT) begin
                        stateNext_s = RESP;
                    end else begin
                        stateNext_s = WAITING;
                        cntNext_s   = CNT_RELOAD;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            WAITING: begin
                if (cnt_r == CNT_ZERO) begin
                    stateNext_s = RESP;
                end else begin
                    cntNext_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                stateNext_s = IDLE;
                cntNext_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and response-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            rvalid_r <= 1'b0;
        end else begin
            state_r  <= stateNext_s;
            cnt_r    <= cntNext_s;
            rvalid_r <= (stateNext_s == RESP);
        end
    end

    // Request latch so the pipeline may drop its inputs after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            reqWen_r   <= WEN_NONE;
            reqAddr_r  <= {ADDR_W{1'b0}};
            reqWdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            reqWen_r   <= wen;
            reqAddr_r  <= addr[ADDR_W+1:2];
            reqWdata_r <= wdata;
        end else begin
            reqWen_r   <= reqWen_r;
            reqAddr_r  <= reqAddr_r;
            reqWdata_r <= reqWdata_r;
        end
    end

    // Zero-wait commits use the live request; delayed commits use the latch.
    always_comb begin
        if (state_r == WAITING) begin
            ramWen_s   = reqWen_r;
            ramAddr_s  = reqAddr_r;
            ramWdata_s = reqWdata_r;
        end else begin
            ramWen_s   = wen;
            ramAddr_s  = addr[ADDR_W+1:2];
            ramWdata_s = wdata;
        end
    end

    bram_be #(
        .ADDR_W (ADDR_W)
    ) uRam (
        .clk      (clk),
        .rst      (rst),
        .req      (commit_s),
        .wen      (ramWen_s),
        .wordAddr (ramAddr_s),
        .wdata    (ramWdata_s),
        .rdata    (rdata)
    );

    assign rvalid = rvalid_r;
    assign busy   = (state_r == WAITING) || (en && !ZERO_WAIT && (state_r != WAITING));

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench: four responders with WAIT = 0..3 share one clock; each scenario
// task drives one instance and compares against hand-computed values.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en     [4];
    logic [3:0]  wen    [4];
    logic [31:0] addr   [4];
    logic [31:0] wdata  [4];
    logic [31:0] rdata  [4];
    logic        rvalid [4];
    logic        busy   [4];

    int vecCount = 0;
    int errCount = 0;

    for (genvar g = 0; g < 4; g++) begin : gDut
        data_ram_responder #(.ADDR_W(10), .WAIT(g)) dut (
            .clk(clk), .rst(rst), .en(en[g]), .wen(wen[g]), .addr(addr[g]),
            .wdata(wdata[g]), .rdata(rdata[g]), .rvalid(rvalid[g]), .busy(busy[g])
        );
    end

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        en[k] = e; wen[k] = w; addr[k] = a; wdata[k] = d;
    endtask

    // One isolated request: returns response word and cycles from accept edge to rvalid.
    task automatic doOp(input int k, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        drive(k, 1'b1, w, a, d);
        tick();
        drive(k, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = 1;
        while (!rvalid[k] && lat < 20) begin
            tick();
            lat++;
        end
        if (!rvalid[k]) begin
            vecCount++; errCount++;
            $display("FAIL op_timeout inst%0d: no rvalid after %0d cycles, required %0d", k, lat, k + 1);
        end
        rd = rdata[k];
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            vecCount++; if (rvalid[k] !== 1'b0) begin errCount++; $display("FAIL rst_rvalid inst%0d: got %b want 0", k, rvalid[k]); end
            vecCount++; if (rdata[k] !== 32'h0) begin errCount++; $display("FAIL rst_rdata inst%0d: got %h want 00000000", k, rdata[k]); end
            vecCount++; if (busy[k] !== 1'b0) begin errCount++; $display("FAIL rst_busy inst%0d: got %b want 0", k, busy[k]); end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wait0();
        drive(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        #1;
        vecCount++; if (busy[0] !== 1'b0) begin errCount++; $display("FAIL w0_busy_wr: got %b want 0", busy[0]); end
        tick();
        vecCount++; if (rvalid[0] !== 1'b1) begin errCount++; $display("FAIL w0_rvalid_wr: got %b want 1", rvalid[0]); end
        vecCount++; if (rdata[0] !== 32'hDEADBEEF) begin errCount++; $display("FAIL w0_rdata_wr: got %h want deadbeef", rdata[0]); end
        drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
        #1;
        vecCount++; if (busy[0] !== 1'b0) begin errCount++; $display("FAIL w0_busy_rd: got %b want 0", busy[0]); end
        tick();
        vecCount++; if (rvalid[0] !== 1'b1) begin errCount++; $display("FAIL w0_rvalid_rd: got %b want 1", rvalid[0]); end
        vecCount++; if (rdata[0] !== 32'hDEADBEEF) begin errCount++; $display("FAIL w0_rdata_rd: got %h want deadbeef", rdata[0]); end
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        vecCount++; if (rvalid[0] !== 1'b0) begin errCount++; $display("FAIL w0_rvalid_idle: got %b want 0", rvalid[0]); end
        vecCount++; if (rdata[0] !== 32'hDEADBEEF) begin errCount++; $display("FAIL w0_rdata_hold: got %h want deadbeef", rdata[0]); end
    endtask

    task automatic test_wait2();
        logic [31:0] rd;
        int lat;
        doOp(2, 4'hF, 32'h20, 32'h12345678, rd, lat);
        vecCount++; if (lat !== 3) begin errCount++; $display("FAIL w2_latency: got %0d want 3", lat); end
        doOp(2, 4'hF, 32'h24, 32'h55AA55AA, rd, lat);
        drive(2, 1'b1, 4'h0, 32'h20, 32'h0);
        #1;
        vecCount++; if (busy[2] !== 1'b1) begin errCount++; $display("FAIL w2_busy_accept: got %b want 1", busy[2]); end
        tick();
        drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int c = 1; c <= 2; c++) begin
            vecCount++; if (busy[2] !== 1'b1 || rvalid[2] !== 1'b0) begin errCount++; $display("FAIL w2_wait%0d: got busy=%b rvalid=%b want busy=1 rvalid=0", c, busy[2], rvalid[2]); end
            vecCount++; if (rdata[2] !== 32'h55AA55AA) begin errCount++; $display("FAIL w2_rdata_hold%0d: got %h want 55aa55aa", c, rdata[2]); end
            tick();
        end
        vecCount++; if (rvalid[2] !== 1'b1) begin errCount++; $display("FAIL w2_rvalid: got %b want 1", rvalid[2]); end
        vecCount++; if (rdata[2] !== 32'h12345678) begin errCount++; $display("FAIL w2_rdata: got %h want 12345678", rdata[2]); end
        vecCount++; if (busy[2] !== 1'b0) begin errCount++; $display("FAIL w2_busy_resp: got %b want 0", busy[2]); end
        tick();
        vecCount++; if (rvalid[2] !== 1'b0) begin errCount++; $display("FAIL w2_rvalid_pulse: got %b want 0", rvalid[2]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int lat;
        doOp(1, 4'hF, 32'h40, 32'h11223344, rd, lat);
        doOp(1, 4'b0101, 32'h40, 32'hAABBCCDD, rd, lat);
        vecCount++; if (rd !== 32'h11BB33DD) begin errCount++; $display("FAIL lanes_wr_rdata: got %h want 11bb33dd", rd); end
        vecCount++; if (lat !== 2) begin errCount++; $display("FAIL lanes_latency: got %0d want 2", lat); end
        doOp(1, 4'h0, 32'h40, 32'h0, rd, lat);
        vecCount++; if (rd !== 32'h11BB33DD) begin errCount++; $display("FAIL lanes_rd_rdata: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        drive(1, 1'b1, 4'h0, 32'h40, 32'h0);
        tick();
        drive(1, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
        #1;
        vecCount++; if (busy[1] !== 1'b1 || rvalid[1] !== 1'b0) begin errCount++; $display("FAIL b2b_waitA: got busy=%b rvalid=%b want busy=1 rvalid=0", busy[1], rvalid[1]); end
        tick();
        vecCount++; if (rvalid[1] !== 1'b1) begin errCount++; $display("FAIL b2b_rvalidA: got %b want 1", rvalid[1]); end
        vecCount++; if (rdata[1] !== 32'h11BB33DD) begin errCount++; $display("FAIL b2b_rdataA: got %h want 11bb33dd", rdata[1]); end
        drive(1, 1'b1, 4'hF, 32'h48, 32'h0BADF00D);
        #1;
        vecCount++; if (busy[1] !== 1'b1) begin errCount++; $display("FAIL b2b_busy_acceptB: got %b want 1", busy[1]); end
        tick();
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        vecCount++; if (rvalid[1] !== 1'b0 || busy[1] !== 1'b1) begin errCount++; $display("FAIL b2b_waitB: got rvalid=%b busy=%b want rvalid=0 busy=1", rvalid[1], busy[1]); end
        tick();
        vecCount++; if (rvalid[1] !== 1'b1) begin errCount++; $display("FAIL b2b_rvalidB: got %b want 1", rvalid[1]); end
        vecCount++; if (rdata[1] !== 32'h0BADF00D) begin errCount++; $display("FAIL b2b_rdataB: got %h want 0badf00d", rdata[1]); end
        tick();
        vecCount++; if (rvalid[1] !== 1'b0) begin errCount++; $display("FAIL b2b_no_extra: got %b want 0", rvalid[1]); end
        doOp(1, 4'h0, 32'h40, 32'h0, rd, lat);
        vecCount++; if (rd !== 32'h11BB33DD) begin errCount++; $display("FAIL b2b_dropped_write: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        int lat;
        doOp(3, 4'hF, 32'h80, 32'h00000000, rd, lat);
        doOp(3, 4'hF, 32'h84, 32'h77777777, rd, lat);
        drive(3, 1'b1, 4'hF, 32'h80, 32'hCAFEF00D);
        tick();
        drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        vecCount++; if (rvalid[3] !== 1'b0) begin errCount++; $display("FAIL mid_rvalid: got %b want 0", rvalid[3]); end
        vecCount++; if (rdata[3] !== 32'h0) begin errCount++; $display("FAIL mid_rdata: got %h want 00000000", rdata[3]); end
        vecCount++; if (busy[3] !== 1'b0) begin errCount++; $display("FAIL mid_busy: got %b want 0", busy[3]); end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            vecCount++; if (rvalid[3] !== 1'b0) begin errCount++; $display("FAIL mid_late_rvalid cycle%0d: got %b want 0", c, rvalid[3]); end
        end
        doOp(3, 4'h0, 32'h80, 32'h0, rd, lat);
        vecCount++; if (rd !== 32'h00000000) begin errCount++; $display("FAIL mid_aborted_write: got %h want 00000000", rd); end
        vecCount++; if (lat !== 4) begin errCount++; $display("FAIL mid_latency: got %0d want 4", lat); end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        int lat;
        doOp(0, 4'hF, 32'h00001004, 32'h5A5A5A5A, rd, lat);
        vecCount++; if (lat !== 1) begin errCount++; $display("FAIL alias_latency: got %0d want 1", lat); end
        doOp(0, 4'h0, 32'h00000004, 32'h0, rd, lat);
        vecCount++; if (rd !== 32'h5A5A5A5A) begin errCount++; $display("FAIL alias_high_bits: got %h want 5a5a5a5a", rd); end
        doOp(0, 4'h0, 32'h00000007, 32'h0, rd, lat);
        vecCount++; if (rd !== 32'h5A5A5A5A) begin errCount++; $display("FAIL alias_low_bits: got %h want 5a5a5a5a", rd); end
        doOp(0, 4'h0, 32'h00000010, 32'h0, rd, lat);
        vecCount++; if (rd !== 32'hDEADBEEF) begin errCount++; $display("FAIL alias_neighbour: got %h want deadbeef", rd); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wait0();
        test_wait2();
        test_byte_lanes();
        test_back_to_back();
        test_reset_midop();
        test_alias();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
